// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
// The queue entry pairs each fetched instruction with the PC it came from.
package fetch_pkg;

  localparam int INSTR_W = 16;
  localparam int PC_W    = 16;
  localparam int PC_INC  = 2;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } ifq_entry_t;

  // Instructions are halfword aligned, so the low PC bit is always dropped.
  function automatic logic [PC_W-1:0] alignPc(input logic [PC_W-1:0] pc);
    return {pc[PC_W-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Prefetch FIFO of {pc, instr} entries with a synchronous flush.
// The owner guarantees push only with free space (or a same-cycle pop)
// and pop only when the FIFO holds at least one entry.
module ifq_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  ifq_entry_t             i_wdata,
  output ifq_entry_t             o_rdata,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  ifq_entry_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;

  // Entry storage needs no reset: count gates whether the head is meaningful.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) begin
      r_mem[r_wrPtr] <= i_wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; flush wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (i_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rdPtr];
  assign o_count = r_count;

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: sequential PC generator feeding a prefetch FIFO
// that hands {pc, instr} to decode over a valid/ready handshake.
// Optional feature macro: IFQ_PERF_EN adds saturating fetch/stall counters.
// ADDR_WIDTH must match fetch_pkg::PC_W since queue entries carry the PC.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 16'h0000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic                  imem_enable,
  output logic                  imem_wr,
  output logic [INSTR_W-1:0]    imem_data_in,
  input  logic [INSTR_W-1:0]    imem_data_out,
  input  logic                  halt,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  dec_valid,
  input  logic                  dec_ready,
  output logic [INSTR_W-1:0]    dec_instr,
  output logic [ADDR_WIDTH-1:0] dec_pc
`ifdef IFQ_PERF_EN
  ,
  output logic [15:0]           perf_fetch_cnt,
  output logic [15:0]           perf_stall_cnt
`endif
);

  localparam int                CNT_W     = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);

  logic [ADDR_WIDTH-1:0] r_fetchPc;
  logic [CNT_W-1:0]      w_count;
  logic                  w_pop;
  logic                  w_space;
  logic                  w_fetch;
  ifq_entry_t            w_wrEntry;
  ifq_entry_t            w_head;

  // A redirect suppresses both pop and fetch so the flush sees a quiet queue.
  assign dec_valid = (w_count != '0);
  assign w_pop     = dec_valid & dec_ready & ~redirect_valid;
  assign w_space   = (w_count < DEPTH_CNT) | w_pop;
  assign w_fetch   = ~rst & ~halt & ~redirect_valid & w_space;

  assign imem_enable  = w_fetch;
  assign imem_addr    = r_fetchPc;
  assign imem_wr      = 1'b0;
  assign imem_data_in = '0;

  assign w_wrEntry.pc    = r_fetchPc;
  assign w_wrEntry.instr = imem_data_out;

  // Fetch PC: redirect loads an aligned target, each fetch steps one halfword.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetchPc <= RESET_PC;
    end else if (redirect_valid) begin
      r_fetchPc <= alignPc(redirect_pc);
    end else if (w_fetch) begin
      r_fetchPc <= r_fetchPc + ADDR_WIDTH'(PC_INC);
    end
  end

  ifq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (redirect_valid),
    .i_push  (w_fetch),
    .i_pop   (w_pop),
    .i_wdata (w_wrEntry),
    .o_rdata (w_head),
    .o_count (w_count)
  );

  assign dec_instr = w_head.instr;
  assign dec_pc    = w_head.pc;

`ifdef IFQ_PERF_EN
  logic [15:0] r_perfFetch;
  logic [15:0] r_perfStall;
  logic        w_stall;

  assign w_stall = ~halt & ~redirect_valid & ~w_space;

  // Saturating event counters: fetch cycles and cycles lost to a full queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perfFetch <= '0;
      r_perfStall <= '0;
    end else begin
      if (w_fetch && (r_perfFetch != 16'hFFFF)) begin
        r_perfFetch <= r_perfFetch + 16'd1;
      end
      if (w_stall && (r_perfStall != 16'hFFFF)) begin
        r_perfStall <= r_perfStall + 16'd1;
      end
    end
  end

  assign perf_fetch_cnt = r_perfFetch;
  assign perf_stall_cnt = r_perfStall;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: directed scenarios followed by
// randomized halt/redirect/ready traffic, all compared against a queue model.
module tb_instr_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk;
  logic        rst;
  logic [15:0] imem_addr;
  logic        imem_enable;
  logic        imem_wr;
  logic [15:0] imem_data_in;
  logic [15:0] imem_data_out;
  logic        halt;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [15:0] dec_instr;
  logic [15:0] dec_pc;
`ifdef IFQ_PERF_EN
  logic [15:0] perf_fetch_cnt;
  logic [15:0] perf_stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
  } modelEntry_t;

  modelEntry_t modelQ[$];
  logic [15:0] modelPc;
  int          modelFetchCnt;
  int          modelStallCnt;

  instr_fetch_queue #(
    .ADDR_WIDTH (16),
    .DEPTH      (DEPTH),
    .RESET_PC   (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_enable    (imem_enable),
    .imem_wr        (imem_wr),
    .imem_data_in   (imem_data_in),
    .imem_data_out  (imem_data_out),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc)
`ifdef IFQ_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory contents: fixed words at 0..6, an address hash elsewhere.
  function automatic logic [15:0] memWord(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h1111;
      16'h0002: return 16'h2222;
      16'h0004: return 16'h3333;
      16'h0006: return 16'h4444;
      default:  return {a[7:0] ^ 8'h3C, a[15:8] ^ 8'hC5};
    endcase
  endfunction

  // Combinational read port, same-cycle data for the presented address.
  always_comb imem_data_out = memWord(imem_addr);

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    modelQ.delete();
    modelPc       = RESET_PC;
    modelFetchCnt = 0;
    modelStallCnt = 0;
  endtask

  // One clock cycle: drive inputs at the falling edge, check just after,
  // then advance the model to the state after the following rising edge.
  task automatic applyStimulus(input logic h, input logic rv,
                               input logic [15:0] rpc, input logic rdy);
    logic expValid;
    logic expPop;
    logic expSpace;
    logic expFetch;
    modelEntry_t e;
    @(negedge clk);
    rst            = 1'b0;
    halt           = h;
    redirect_valid = rv;
    redirect_pc    = rpc;
    dec_ready      = rdy;
    #1;
    expValid = (modelQ.size() != 0);
    expPop   = expValid && rdy && !rv;
    expSpace = (modelQ.size() < DEPTH) || expPop;
    expFetch = !h && !rv && expSpace;

    checkOutput("dec_valid", {31'd0, dec_valid}, {31'd0, expValid});
    checkOutput("imem_enable", {31'd0, imem_enable}, {31'd0, expFetch});
    checkOutput("imem_addr", {16'd0, imem_addr}, {16'd0, modelPc});
    checkOutput("imem_wr", {31'd0, imem_wr}, 32'd0);
    checkOutput("imem_data_in", {16'd0, imem_data_in}, 32'd0);
    if (expValid) begin
      checkOutput("dec_pc", {16'd0, dec_pc}, {16'd0, modelQ[0].pc});
      checkOutput("dec_instr", {16'd0, dec_instr}, {16'd0, modelQ[0].instr});
    end
`ifdef IFQ_PERF_EN
    checkOutput("perf_fetch_cnt", {16'd0, perf_fetch_cnt}, modelFetchCnt);
    checkOutput("perf_stall_cnt", {16'd0, perf_stall_cnt}, modelStallCnt);
`endif

    if (rv) begin
      modelQ.delete();
      modelPc = {rpc[15:1], 1'b0};
    end else begin
      if (expPop) begin
        void'(modelQ.pop_front());
      end
      if (expFetch) begin
        e.pc    = modelPc;
        e.instr = memWord(modelPc);
        modelQ.push_back(e);
        modelPc = modelPc + 16'd2;
      end
    end
    if (expFetch && modelFetchCnt < 65535) modelFetchCnt++;
    if (!h && !rv && !expSpace && modelStallCnt < 65535) modelStallCnt++;
  endtask

  // Raise reset between clock edges; it stays high until the next stimulus.
  task automatic asyncResetPulse();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_dec_valid", {31'd0, dec_valid}, 32'd0);
    checkOutput("rst_imem_enable", {31'd0, imem_enable}, 32'd0);
    checkOutput("rst_imem_addr", {16'd0, imem_addr}, {16'd0, RESET_PC});
`ifdef IFQ_PERF_EN
    checkOutput("rst_perf_fetch", {16'd0, perf_fetch_cnt}, 32'd0);
    checkOutput("rst_perf_stall", {16'd0, perf_stall_cnt}, 32'd0);
`endif
    modelReset();
  endtask

  initial begin
    rst            = 1'b1;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    dec_ready      = 1'b0;
    modelReset();

    @(negedge clk);
    #1;
    checkOutput("reset_dec_valid", {31'd0, dec_valid}, 32'd0);
    checkOutput("reset_imem_enable", {31'd0, imem_enable}, 32'd0);
    checkOutput("reset_imem_addr", {16'd0, imem_addr}, {16'd0, RESET_PC});

    // Decode stalled: four fetches fill the queue, then fetch stops at PC 8.
    repeat (10) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    // Decode resumes: pop and fetch of address 8 in the same cycle.
    repeat (4) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    // Refill, then redirect to an odd target while full.
    repeat (5) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h0041, 1'b0);
    repeat (4) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    // PC wrap across the top of the address space.
    applyStimulus(1'b0, 1'b1, 16'hFFFC, 1'b1);
    repeat (6) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    // Queue three entries, then halt and let them drain.
    applyStimulus(1'b0, 1'b1, 16'h0200, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    repeat (5) applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
    // Redirect while halted: flush and load, but no fetch until halt drops.
    applyStimulus(1'b1, 1'b1, 16'h0300, 1'b1);
    repeat (2) applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
    repeat (3) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    // Two entries queued, then an asynchronous reset between edges.
    applyStimulus(1'b0, 1'b1, 16'h0100, 1'b0);
    repeat (2) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    asyncResetPulse();
    repeat (3) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);

    // Randomized traffic with occasional redirects, halts and resets.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        asyncResetPulse();
      end
      applyStimulus($urandom_range(0, 7) == 0,
                    $urandom_range(0, 11) == 0,
                    16'($urandom),
                    $urandom_range(0, 3) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
